conv_mac_engine: RTL and testbench

Parametrised successor of the fixed 32-channel, 4-bit convolution block. It loads a DEPTH x N_CH signed weight bank through its own weight_valid stream instead of hard-wired weights. It then accumulates DEPTH beats of N_CH-wide unsigned IFM vectors into one OFM value per frame. It sits between the IFM line-buffer and the OFM writer, and is driven by the PATTERN bench in the same way.

---
 rtl/conv_pkg.sv | 16 +
 rtl/conv_adder_tree.sv | 25 ++
 rtl/conv_mac_engine.sv | 131 +++++++++++++
 tb/tb_conv_mac_engine.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared types, defaults and the OFM width helper for the convolution MAC engine.
package conv_pkg;

  localparam int unsigned N_CH_DEF = 32;
  localparam int unsigned DW_DEF   = 4;
  localparam int unsigned WW_DEF   = 4;

  typedef enum logic [0:0] {W_LOAD, RUN} conv_state_e;

  // Wide enough for the most negative frame sum, so the accumulator never overflows.
  function automatic int unsigned ofm_width(input int unsigned n_ch, input int unsigned dw,
                                            input int unsigned ww, input int unsigned depth);
    return dw + ww + $clog2(n_ch * depth) + 1;
  endfunction

endpackage

// File: rtl/conv_adder_tree.sv
// Sums N_CH signed lane products into one sign-extended value, one registered output stage.
module conv_adder_tree #(
  parameter int unsigned N_CH = 32,
  parameter int unsigned IW   = 9,
  localparam int unsigned SW  = IW + $clog2(N_CH)
) (
  input  logic                 clk_i,
  input  logic [N_CH*IW-1:0]   data_i,
  output logic signed [SW-1:0] sum_o
);

  logic signed [SW-1:0] sum_d;

  always_comb begin
    sum_d = '0;
    for (int i = 0; i < N_CH; i++) begin
      sum_d = sum_d + SW'($signed(data_i[i*IW +: IW]));
    end
  end

  always_ff @(posedge clk_i) begin
    sum_o <= sum_d;
  end

endmodule

// File: rtl/conv_mac_engine.sv
// Weight-bank loader plus 3-stage multiply / adder-tree / accumulate pipeline, one OFM per frame.
// Optional CONV_MAC_RELU_EN clamps negative frame results to zero.
module conv_mac_engine
  import conv_pkg::*;
#(
  parameter int unsigned N_CH  = N_CH_DEF,
  parameter int unsigned DW    = DW_DEF,
  parameter int unsigned WW    = WW_DEF,
  parameter int unsigned DEPTH = 9,
  localparam int unsigned OW   = ofm_width(N_CH, DW, WW, DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 weight_valid,
  input  logic [N_CH*WW-1:0]   In_Weight,
  input  logic                 in_valid,
  input  logic [N_CH*DW-1:0]   In_IFM,
  output logic                 w_ready,
  output logic                 busy,
  output logic                 out_valid,
  output logic signed [OW-1:0] Out_OFM
);

  localparam int unsigned PW = DW + WW + 1;
  localparam int unsigned SW = PW + $clog2(N_CH);
  localparam int unsigned CW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

  conv_state_e          state_q;
  logic [CW-1:0]        wcnt_q, icnt_q, w_row;
  logic [N_CH*WW-1:0]   wbank [DEPTH];
  logic                 w_we, beat;
  logic [N_CH*PW-1:0]   prod_d, prod_q;
  logic                 v1_q, f1_q, l1_q, v2_q, f2_q, l2_q;
  logic signed [SW-1:0] sum2;
  logic signed [OW-1:0] acc_q, acc_d, ofm_d;

  assign busy  = (icnt_q != '0);
  // In RUN a weight beat only counts between frames and always restarts at row 0.
  assign w_we  = weight_valid && ((state_q == W_LOAD) || !busy);
  assign w_row = (state_q == RUN) ? '0 : wcnt_q;
  assign beat  = in_valid && (state_q == RUN) && !w_we;

  always_ff @(posedge clk) begin
    if (w_we) wbank[w_row] <= In_Weight;
  end

  // Unsigned IFM lane is zero-extended so the product is a plain signed multiply.
  always_comb begin
    prod_d = '0;
    for (int i = 0; i < N_CH; i++) begin
      prod_d[i*PW +: PW] = PW'($signed({1'b0, In_IFM[i*DW +: DW]})) *
                           PW'($signed(wbank[icnt_q][i*WW +: WW]));
    end
  end

  always_ff @(posedge clk) begin
    prod_q <= prod_d;
  end

  conv_adder_tree #(
    .N_CH (N_CH),
    .IW   (PW)
  ) u_tree (
    .clk_i  (clk),
    .data_i (prod_q),
    .sum_o  (sum2)
  );

  always_comb begin
    acc_d = f2_q ? OW'(sum2) : acc_q + OW'(sum2);
    ofm_d = acc_d;
`ifdef CONV_MAC_RELU_EN
    if (acc_d[OW-1]) ofm_d = '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= W_LOAD;
      wcnt_q    <= '0;
      icnt_q    <= '0;
      w_ready   <= 1'b0;
      v1_q      <= 1'b0;
      f1_q      <= 1'b0;
      l1_q      <= 1'b0;
      v2_q      <= 1'b0;
      f2_q      <= 1'b0;
      l2_q      <= 1'b0;
      acc_q     <= '0;
      out_valid <= 1'b0;
      Out_OFM   <= '0;
    end else begin
      unique case (state_q)
        W_LOAD: begin
          if (weight_valid) begin
            if (wcnt_q == LAST) begin
              wcnt_q  <= '0;
              w_ready <= 1'b1;
              state_q <= RUN;
            end else begin
              wcnt_q <= wcnt_q + 1'b1;
            end
          end
        end
        RUN: begin
          // With a single-row bank the row-0 write already completes the reload.
          if (w_we && (DEPTH > 1)) begin
            wcnt_q  <= CW'(1);
            w_ready <= 1'b0;
            state_q <= W_LOAD;
          end
        end
      endcase

      if (beat) icnt_q <= (icnt_q == LAST) ? '0 : icnt_q + 1'b1;

      v1_q <= beat;
      f1_q <= (icnt_q == '0);
      l1_q <= (icnt_q == LAST);
      v2_q <= v1_q;
      f2_q <= f1_q;
      l2_q <= l1_q;

      if (v2_q) acc_q <= acc_d;
      out_valid <= v2_q && l2_q;
      if (v2_q && l2_q) Out_OFM <= ofm_d;
    end
  end

endmodule

// File: tb/tb_conv_mac_engine.sv
// Self-checking bench for conv_mac_engine against a frame-level dot-product model.
module tb_conv_mac_engine;

  localparam int N_CH  = 32;
  localparam int DW    = 4;
  localparam int WW    = 4;
  localparam int DEPTH = 9;
  localparam int OW    = DW + WW + $clog2(N_CH * DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              weight_valid;
  logic [N_CH*WW-1:0] In_Weight;
  logic              in_valid;
  logic [N_CH*DW-1:0] In_IFM;
  logic              w_ready, busy, out_valid;
  logic [OW-1:0]     Out_OFM;

  always #5 clk = ~clk;

  conv_mac_engine #(
    .N_CH  (N_CH),
    .DW    (DW),
    .WW    (WW),
    .DEPTH (DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .weight_valid (weight_valid),
    .In_Weight    (In_Weight),
    .in_valid     (in_valid),
    .In_IFM       (In_IFM),
    .w_ready      (w_ready),
    .busy         (busy),
    .out_valid    (out_valid),
    .Out_OFM      (Out_OFM)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int res_q[$];
  int rcyc_q[$];
  int wm [DEPTH][N_CH];
  logic [N_CH*DW-1:0] fr [DEPTH];

  // Advance one clock; outputs are sampled 1ns after the edge and results logged.
  task automatic step();
    @(posedge clk);
    cyc++;
    #1;
    if (out_valid === 1'b1) begin
      res_q.push_back(int'($signed(Out_OFM)));
      rcyc_q.push_back(cyc);
    end
  endtask

  function automatic int res_at(int i);
    return (i < res_q.size()) ? res_q[i] : 32'h7fffffff;
  endfunction

  function automatic int rcyc_at(int i);
    return (i < rcyc_q.size()) ? rcyc_q[i] : -1;
  endfunction

  task automatic clear_res();
    res_q.delete();
    rcyc_q.delete();
  endtask

  function automatic logic [N_CH*WW-1:0] pack_row(int r);
    logic [N_CH*WW-1:0] v;
    for (int l = 0; l < N_CH; l++) v[l*WW +: WW] = WW'(wm[r][l]);
    return v;
  endfunction

  task automatic set_wm_const(int v);
    for (int r = 0; r < DEPTH; r++)
      for (int l = 0; l < N_CH; l++) wm[r][l] = v;
  endtask

  task automatic set_wm_rand();
    for (int r = 0; r < DEPTH; r++)
      for (int l = 0; l < N_CH; l++) wm[r][l] = int'($urandom_range(0, 15)) - 8;
  endtask

  task automatic fill_const(int v);
    for (int r = 0; r < DEPTH; r++)
      for (int l = 0; l < N_CH; l++) fr[r][l*DW +: DW] = DW'(v);
  endtask

  task automatic fill_rand();
    for (int r = 0; r < DEPTH; r++)
      for (int l = 0; l < N_CH; l++) fr[r][l*DW +: DW] = DW'($urandom_range(0, 15));
  endtask

  // Frame result straight from the definition: sum of IFM x weight over every tap and lane.
  function automatic int model_frame();
    int s = 0;
    for (int r = 0; r < DEPTH; r++)
      for (int l = 0; l < N_CH; l++) s += int'(fr[r][l*DW +: DW]) * wm[r][l];
`ifdef CONV_MAC_RELU_EN
    if (s < 0) s = 0;
`endif
    return s;
  endfunction

  task automatic load_weights();
    for (int r = 0; r < DEPTH; r++) begin
      weight_valid = 1'b1;
      In_Weight    = pack_row(r);
      step();
    end
    weight_valid = 1'b0;
  endtask

  task automatic send_frame(input int gap_max, output int last);
    for (int b = 0; b < DEPTH; b++) begin
      repeat ($urandom_range(0, gap_max)) begin
        In_IFM = '1;
        step();
      end
      in_valid = 1'b1;
      In_IFM   = fr[b];
      step();
      in_valid = 1'b0;
    end
    last = cyc;
  endtask

  task automatic test_reset();
    rst = 1'b1; weight_valid = 1'b0; in_valid = 1'b0; In_Weight = '0; In_IFM = '0;
    repeat (3) step();
    total++; if (w_ready !== 1'b0) begin bad++; $display("FAIL reset_w_ready: got %b want 0", w_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    total++; if (Out_OFM !== '0) begin bad++; $display("FAIL reset_ofm: got %0d want 0", Out_OFM); end
    rst = 1'b0;
    step();
    clear_res();
  endtask

  task automatic test_ones();
    int last;
    set_wm_const(1);
    load_weights();
    total++; if (w_ready !== 1'b1) begin bad++; $display("FAIL ones_w_ready: got %b want 1", w_ready); end
    fill_const(15);
    clear_res();
    for (int b = 0; b < DEPTH; b++) begin
      in_valid = 1'b1; In_IFM = fr[b];
      step();
      in_valid = 1'b0;
      if (b == 3) begin
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL ones_busy_mid: got %b want 1", busy); end
      end
    end
    last = cyc;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ones_busy_end: got %b want 0", busy); end
    repeat (4) step();
    total++; if (res_q.size() != 1) begin bad++; $display("FAIL ones_count: got %0d want 1", res_q.size()); end
    total++; if (res_at(0) != 4320) begin bad++; $display("FAIL ones_value: got %0d want 4320", res_at(0)); end
    total++; if (rcyc_at(0) != last + 2) begin bad++; $display("FAIL ones_latency: got cycle %0d want %0d", rcyc_at(0), last + 2); end
  endtask

  task automatic test_neg();
    int last, exp_v;
    set_wm_const(-8);
    load_weights();
    fill_const(15);
    clear_res();
    send_frame(0, last);
    repeat (4) step();
`ifdef CONV_MAC_RELU_EN
    exp_v = 0;
`else
    exp_v = -34560;
`endif
    total++; if (res_q.size() != 1) begin bad++; $display("FAIL neg_count: got %0d want 1", res_q.size()); end
    total++; if (res_at(0) != exp_v) begin bad++; $display("FAIL neg_value: got %0d want %0d", res_at(0), exp_v); end
  endtask

  task automatic test_back_to_back();
    int l1, l2;
    set_wm_const(1);
    load_weights();
    clear_res();
    fill_const(1);
    send_frame(0, l1);
    fill_const(2);
    send_frame(0, l2);
    repeat (4) step();
    total++; if (res_q.size() != 2) begin bad++; $display("FAIL b2b_count: got %0d want 2", res_q.size()); end
    total++; if (res_at(0) != 288) begin bad++; $display("FAIL b2b_value0: got %0d want 288", res_at(0)); end
    total++; if (res_at(1) != 576) begin bad++; $display("FAIL b2b_value1: got %0d want 576", res_at(1)); end
    total++; if (rcyc_at(0) != l1 + 2) begin bad++; $display("FAIL b2b_cycle0: got %0d want %0d", rcyc_at(0), l1 + 2); end
    total++; if (rcyc_at(1) != l2 + 2) begin bad++; $display("FAIL b2b_cycle1: got %0d want %0d", rcyc_at(1), l2 + 2); end
  endtask

  task automatic test_gaps_wdrop();
    int l0, l1, l2, exp_v;
    set_wm_rand();
    load_weights();
    fill_rand();
    exp_v = model_frame();
    clear_res();
    send_frame(0, l0);
    for (int b = 0; b < DEPTH; b++) begin
      repeat ($urandom_range(0, 3)) begin In_IFM = '1; step(); end
      if (b == 4) begin
        weight_valid = 1'b1; In_Weight = {N_CH{4'h7}};
        step();
        weight_valid = 1'b0;
      end
      if (b == 6) begin
        weight_valid = 1'b1; In_Weight = {N_CH{4'h7}};
      end
      in_valid = 1'b1; In_IFM = fr[b];
      step();
      in_valid = 1'b0; weight_valid = 1'b0;
    end
    l1 = cyc;
    total++; if (w_ready !== 1'b1) begin bad++; $display("FAIL gap_w_ready: got %b want 1", w_ready); end
    send_frame(2, l2);
    repeat (4) step();
    total++; if (res_q.size() != 3) begin bad++; $display("FAIL gap_count: got %0d want 3", res_q.size()); end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (res_at(i) != exp_v) begin bad++; $display("FAIL gap_value%0d: got %0d want %0d", i, res_at(i), exp_v); end
    end
    total++; if (rcyc_at(1) != l1 + 2) begin bad++; $display("FAIL gap_latency: got %0d want %0d", rcyc_at(1), l1 + 2); end
  endtask

  task automatic test_rst_mid();
    int last, exp_v;
    set_wm_rand();
    load_weights();
    fill_rand();
    clear_res();
    for (int b = 0; b < 4; b++) begin
      in_valid = 1'b1; In_IFM = fr[b];
      step();
    end
    rst = 1'b1; In_IFM = fr[4];
    step();
    rst = 1'b0; in_valid = 1'b0;
    total++; if (w_ready !== 1'b0) begin bad++; $display("FAIL rst_w_ready: got %b want 0", w_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    send_frame(0, last);
    repeat (4) step();
    total++; if (res_q.size() != 0) begin bad++; $display("FAIL rst_no_out: got %0d results want 0", res_q.size()); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_ignore_ifm: got busy %b want 0", busy); end
    set_wm_rand();
    load_weights();
    total++; if (w_ready !== 1'b1) begin bad++; $display("FAIL rst_reload_ready: got %b want 1", w_ready); end
    fill_rand();
    exp_v = model_frame();
    send_frame(1, last);
    repeat (4) step();
    total++; if (res_at(0) != exp_v) begin bad++; $display("FAIL rst_after_value: got %0d want %0d", res_at(0), exp_v); end
  endtask

  task automatic test_reload();
    int last, exp_v;
    set_wm_rand();
    clear_res();
    for (int r = 0; r < DEPTH; r++) begin
      weight_valid = 1'b1; In_Weight = pack_row(r);
      in_valid = 1'b1;
      for (int l = 0; l < N_CH; l++) In_IFM[l*DW +: DW] = DW'($urandom_range(0, 15));
      step();
      if (r == 0) begin
        total++; if (w_ready !== 1'b0) begin bad++; $display("FAIL reload_w_ready_low: got %b want 0", w_ready); end
      end
    end
    weight_valid = 1'b0; in_valid = 1'b0;
    total++; if (w_ready !== 1'b1) begin bad++; $display("FAIL reload_w_ready_high: got %b want 1", w_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reload_busy: got %b want 0", busy); end
    repeat (4) step();
    total++; if (res_q.size() != 0) begin bad++; $display("FAIL reload_no_out: got %0d results want 0", res_q.size()); end
    fill_rand();
    exp_v = model_frame();
    send_frame(1, last);
    repeat (4) step();
    total++; if (res_at(0) != exp_v) begin bad++; $display("FAIL reload_value: got %0d want %0d", res_at(0), exp_v); end
  endtask

  task automatic test_random();
    int last, exp_v;
    for (int k = 0; k < 3; k++) begin
      set_wm_rand();
      load_weights();
      fill_rand();
      exp_v = model_frame();
      clear_res();
      send_frame(2, last);
      repeat (4) step();
      total++;
      if (res_at(0) != exp_v) begin bad++; $display("FAIL random%0d: got %0d want %0d", k, res_at(0), exp_v); end
    end
  endtask

  initial begin
    test_reset();
    test_ones();
    test_neg();
    test_back_to_back();
    test_gaps_wdrop();
    test_rst_mid();
    test_reload();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
